fb_write_ctrl: RTL and testbench

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

---
 rtl/fb_write_ctrl.sv | 143 ++++++++++++++
 tb/tb_fb_write_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller: captures one frame of pixels through a small
// FIFO and issues sequential writes to the frame buffer, one per mem_ack.
module fb_write_ctrl #(
    parameter int          DATA_W     = 16,
    parameter logic [19:0] LAST_ADDR  = 20'h4AFFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              mem_wr_en,
    output logic [19:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              frame_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [19:0]       pix_cnt_q, pix_cnt_d;
    logic [19:0]       wr_addr_q, wr_addr_d;
    logic              frame_done_q, frame_done_d;

    logic push, pop, last_pix, last_wr;

    // Handshakes; abort blocks both sides so its cycle never moves data.
    assign pix_ready  = (state_q == ACTIVE) && (count_q < DEPTH_C) && !abort;
    assign mem_wr_en  = (state_q != IDLE) && (count_q != '0);
    assign mem_addr   = wr_addr_q;
    assign mem_wdata  = fifo_mem_q[rd_ptr_q];
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

    assign push     = pix_valid && pix_ready;
    assign pop      = mem_wr_en && mem_ack && !abort;
    assign last_pix = (pix_cnt_q == LAST_ADDR);
    assign last_wr  = (wr_addr_q == LAST_ADDR);

    // Next-state, FIFO bookkeeping and counters.
    always_comb begin
        state_d      = state_q;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        pix_cnt_d    = pix_cnt_q;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;

        if (abort) begin
            // Cancel wins over everything: flush and rewind without a done pulse.
            state_d   = IDLE;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            pix_cnt_d = '0;
            wr_addr_d = '0;
        end else begin
            if (push) begin
                fifo_mem_d[wr_ptr_q] = pix_data;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                pix_cnt_d            = last_pix ? '0 : pix_cnt_q + 20'd1;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                wr_addr_d = last_wr ? '0 : wr_addr_q + 20'd1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = ACTIVE;
                        pix_cnt_d = '0;
                        wr_addr_d = '0;
                    end
                end
                ACTIVE: begin
                    // Final pixel of the frame accepted: stop taking input.
                    if (push && last_pix) state_d = DRAIN;
                end
                DRAIN: begin
                    state_d = DRAIN;
                end
                default: state_d = IDLE;
            endcase

            // Final write acknowledged: frame complete.
            if (pop && last_wr) begin
                state_d      = IDLE;
                pix_cnt_d    = '0;
                frame_done_d = 1'b1;
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pix_cnt_q    <= '0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pix_cnt_q    <= pix_cnt_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= fifo_mem_d[i];
        end
    end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed + randomized bench for fb_write_ctrl with a write scoreboard.
module tb_fb_write_ctrl;

    localparam int          DW   = 16;
    localparam logic [19:0] LA   = 20'd7;
    localparam int          FD   = 4;
    localparam int          NPIX = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;
    logic          mem_ack = 1'b0;
    logic          pix_ready, mem_wr_en, busy, frame_done;
    logic [19:0]   mem_addr;
    logic [DW-1:0] mem_wdata;

    fb_write_ctrl #(.DATA_W(DW), .LAST_ADDR(LA), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [35:0] sb[$];
    int          in_idx = 0;
    int          writes = 0;
    int          fd_cnt = 0;
    logic [15:0] base = '0;
    logic        hold_pending = 1'b0;
    logic [19:0] hold_addr = '0;
    logic [15:0] hold_data = '0;
    logic        last_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample mid-cycle, score handshakes, advance, note frame_done.
    task automatic step();
        logic [35:0] e;
        #2;
        last_ready = pix_ready;
        if (!abort && !rst) begin
            if (hold_pending) begin
                chk("hold_wr_en", 32'(mem_wr_en), 32'd1);
                chk("hold_addr", 32'(mem_addr), 32'(hold_addr));
                chk("hold_data", 32'(mem_wdata), 32'(hold_data));
            end
            hold_pending = 1'b0;
            if (pix_valid && pix_ready) begin
                sb.push_back({20'(in_idx), pix_data});
                in_idx++;
            end
            if (mem_wr_en && mem_ack) begin
                if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e[35:16]));
                    chk("wr_data", 32'(mem_wdata), 32'(e[15:0]));
                end
                writes++;
            end else if (mem_wr_en) begin
                hold_pending = 1'b1;
                hold_addr    = mem_addr;
                hold_data    = mem_wdata;
            end
        end else begin
            hold_pending = 1'b0;
            sb.delete();
        end
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
    endtask

    // Start pulse with a pixel offered while still idle (must not be taken).
    task automatic do_start();
        start     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 16'hDEAD;
        step();
        chk("idle_no_accept", 32'(last_ready), 32'd0);
        start  = 1'b0;
        in_idx = 0;
        writes = 0;
        fd_cnt = 0;
    endtask

    // vmode 1: valid always, 2: random. amode 0: ack low, 1: high, 2: random.
    task automatic run_frame(input int vmode, input int amode, input int budget, input bit tail);
        int n = 0;
        while (fd_cnt == 0 && n < budget) begin
            pix_valid = (in_idx < NPIX) && (vmode == 1 || $urandom_range(1, 0) == 1);
            pix_data  = base + 16'(in_idx);
            mem_ack   = (amode == 1) || (amode == 2 && $urandom_range(1, 0) == 1);
            step();
            n++;
        end
        pix_valid = 1'b0;
        mem_ack   = 1'b0;
        chk("frame_timeout", 32'(fd_cnt != 0), 32'd1);
        chk("write_count", 32'(writes), 32'(NPIX));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        if (tail) begin
            step();
            chk("frame_done_once", 32'(fd_cnt), 32'd1);
            chk("busy_after", 32'(busy), 32'd0);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pix_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_mem_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        #2 rst = 1'b0;

        // Streaming frame, ack always high
        do_start();
        base = 16'h0000;
        run_frame(1, 1, 60, 1'b1);

        // Back-pressure: ack held low fills the FIFO, then released
        do_start();
        base    = 16'h0000;
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pix_valid = (in_idx < NPIX);
            pix_data  = base + 16'(in_idx);
            step();
        end
        chk("bp_accepted", 32'(in_idx), 32'd4);
        #2;
        chk("bp_pix_ready", 32'(pix_ready), 32'd0);
        chk("bp_wr_en", 32'(mem_wr_en), 32'd1);
        chk("bp_addr", 32'(mem_addr), 32'd0);
        chk("bp_wdata", 32'(mem_wdata), 32'h0000);
        run_frame(1, 1, 60, 1'b1);

        // Random valid and ack
        do_start();
        base = 16'hA500;
        run_frame(2, 2, 400, 1'b1);

        // Abort with 3 writes done and 2 pixels buffered
        do_start();
        base = 16'h3300;
        n = 0;
        mem_ack = 1'b0;
        while (in_idx < 4 && n < 20) begin
            pix_valid = 1'b1; pix_data = base + 16'(in_idx); step(); n++;
        end
        pix_valid = 1'b0;
        mem_ack   = 1'b1;
        while (writes < 3 && n < 40) begin step(); n++; end
        mem_ack = 1'b0;
        while (in_idx < 5 && n < 60) begin
            pix_valid = 1'b1; pix_data = base + 16'(in_idx); step(); n++;
        end
        chk("abort_setup_buffered", 32'(sb.size()), 32'd2);
        chk("abort_setup_writes", 32'(writes), 32'd3);
        abort = 1'b1; pix_valid = 1'b1; mem_ack = 1'b1;
        step();
        chk("abort_pix_ready", 32'(last_ready), 32'd0);
        abort = 1'b0; pix_valid = 1'b0; mem_ack = 1'b0;
        chk("abort_wr_en", 32'(mem_wr_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frame_done", 32'(frame_done), 32'd0);
        step();
        chk("abort_no_done", 32'(fd_cnt), 32'd0);
        do_start();
        base = 16'h4400;
        run_frame(1, 1, 60, 1'b1);

        // Asynchronous reset mid-frame
        do_start();
        base = 16'h5500;
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1; pix_data = base + 16'(in_idx); mem_ack = 1'b1; step();
        end
        #2 rst = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        @(posedge clk);
        #3 rst = 1'b0;
        sb.delete();
        hold_pending = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_valid = 1'b1; pix_data = 16'h7777; mem_ack = 1'b1;
            step();
            chk("post_rst_ready", 32'(last_ready), 32'd0);
            chk("post_rst_wr_en", 32'(mem_wr_en), 32'd0);
        end
        pix_valid = 1'b0; mem_ack = 1'b0;

        // Start on the frame_done cycle chains straight into the next frame
        do_start();
        base = 16'h1100;
        run_frame(1, 1, 60, 1'b0);
        chk("chain_fd_high", 32'(frame_done), 32'd1);
        do_start();
        pix_valid = 1'b0;
        #2;
        chk("chain_ready", 32'(pix_ready), 32'd1);
        base = 16'h2200;
        run_frame(1, 1, 60, 1'b1);
        for (int i = 0; i < 2; i++) begin
            pix_valid = 1'b1; pix_data = 16'h9999;
            step();
            chk("idle_ready", 32'(last_ready), 32'd0);
        end
        pix_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
